wb_regfile_writer: RTL

- Consumer end of the MEM/WB pipeline interface: takes the write-back bundle registered on the falling edge and commits it to the 32-entry architectural register file on the following rising edge.
- Performs write-back data selection: ALU result, formatted load data, or jal link address.
- Serves the two ID-stage read ports.
- Keeps a retired-write counter for debug.

---
 rtl/wb_regfile_writer_pkg.sv | 18 +
 rtl/wb_regfile_writer_if.sv | 36 +++
 rtl/wb_regfile_writer_load_formatter.sv | 38 +++
 rtl/wb_regfile_writer.sv | 86 ++++++++
 4 files changed

// File: rtl/wb_regfile_writer_pkg.sv
// Shared constants and encodings for the write-back stage / register file.
package wb_regfile_writer_pkg;

   localparam int DEFAULT_DATA_W   = 32;
   localparam int DEFAULT_ADDR_W   = 5;
   localparam int DEFAULT_NUM_REGS = 32;

   localparam int LINK_REG = 31;
   localparam int ZERO_REG = 0;

   typedef enum logic [1:0] {
      LD_WORD     = 2'b00,
      LD_HALF     = 2'b01,
      LD_BYTE     = 2'b10,
      LD_WORD_ALT = 2'b11
   } load_fmt_e;

endpackage

// File: rtl/wb_regfile_writer_if.sv
// MEM/WB write-back bundle plus the ID-stage read ports of the register file.
interface wb_regfile_writer_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   // No backpressure: RegWrite qualifies the bundle for exactly one rising
   // edge and the register file always accepts it (no ready signal exists).
   logic              RegWrite;
   logic              MemToReg;
   logic [1:0]        LoadData;
   logic              JrAddress;
   logic              JrData;
   logic [DATA_W-1:0] MemReadData;
   logic [DATA_W-1:0] ALUResultIn;
   logic [ADDR_W-1:0] RegAddressIn;
   logic [DATA_W-1:0] PCAdderResultIn;
   logic [ADDR_W-1:0] ReadRegister1;
   logic [ADDR_W-1:0] ReadRegister2;
   logic [DATA_W-1:0] ReadData1;
   logic [DATA_W-1:0] ReadData2;
   logic [DATA_W-1:0] WriteData;
   logic [31:0]       WriteCount;

   modport master (
      output RegWrite, MemToReg, LoadData, JrAddress, JrData, MemReadData,
             ALUResultIn, RegAddressIn, PCAdderResultIn, ReadRegister1, ReadRegister2,
      input  ReadData1, ReadData2, WriteData, WriteCount
   );

   modport slave (
      input  RegWrite, MemToReg, LoadData, JrAddress, JrData, MemReadData,
             ALUResultIn, RegAddressIn, PCAdderResultIn, ReadRegister1, ReadRegister2,
      output ReadData1, ReadData2, WriteData, WriteCount
   );

endinterface

// File: rtl/wb_regfile_writer_load_formatter.sv
// wb_load_formatter: lane select and sign extension of a raw little-endian load word.
module wb_load_formatter
   import wb_regfile_writer_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] mem_data_i,
   input  logic [1:0]        load_fmt_i,
   input  logic [1:0]        offset_i,
   output logic [DATA_W-1:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      case (offset_i)
         2'd0:    byte_sel = mem_data_i[7:0];
         2'd1:    byte_sel = mem_data_i[15:8];
         2'd2:    byte_sel = mem_data_i[23:16];
         default: byte_sel = mem_data_i[31:24];
      endcase
   end

   // Halfword lanes ignore offset bit 0: misaligned halves read the aligned half.
   assign half_sel = offset_i[1] ? mem_data_i[31:16] : mem_data_i[15:0];

   always_comb begin
      data_o = mem_data_i;
      case (load_fmt_i)
         LD_HALF: data_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
         LD_BYTE: data_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         default: data_o = mem_data_i;
      endcase
   end

endmodule

// File: rtl/wb_regfile_writer.sv
// Write-back stage: data select, 32-entry register file commit, ID read ports, retire counter.
// Optional WB_REGFILE_BYPASS_EN forwards the pending write to matching read ports before the edge.
module wb_regfile_writer #(
   parameter int DATA_W   = wb_regfile_writer_pkg::DEFAULT_DATA_W,
   parameter int NUM_REGS = wb_regfile_writer_pkg::DEFAULT_NUM_REGS,
   parameter int ADDR_W   = wb_regfile_writer_pkg::DEFAULT_ADDR_W,
   parameter int LINK_REG = wb_regfile_writer_pkg::LINK_REG
) (
   input  logic                Clk,
   input  logic                Reset,
   wb_regfile_writer_if.slave  bus
);
   import wb_regfile_writer_pkg::*;

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
   localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [31:0]       count_q;
   logic [31:0]       count_d;

   logic [ADDR_W-1:0] dest_addr;
   logic [DATA_W-1:0] load_data;
   logic [DATA_W-1:0] write_data;
   logic              commit;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;

   wb_load_formatter #(
      .DATA_W (DATA_W)
   ) u_load_formatter (
      .mem_data_i (bus.MemReadData),
      .load_fmt_i (bus.LoadData),
      .offset_i   (bus.ALUResultIn[1:0]),
      .data_o     (load_data)
   );

   assign dest_addr = bus.JrAddress ? LINK_ADDR : bus.RegAddressIn;

   // Link address wins over load data, which wins over the ALU result.
   always_comb begin
      write_data = bus.ALUResultIn;
      if (bus.JrData) begin
         write_data = bus.PCAdderResultIn;
      end else if (bus.MemToReg) begin
         write_data = load_data;
      end
   end

   assign commit  = bus.RegWrite && (dest_addr != ZERO_ADDR);
   assign count_d = commit ? count_q + 32'd1 : count_q;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         count_q <= '0;
      end else begin
         if (commit) begin
            regs_q[dest_addr] <= write_data;
         end
         count_q <= count_d;
      end
   end

   always_comb begin
      rd1 = (bus.ReadRegister1 == ZERO_ADDR) ? '0 : regs_q[bus.ReadRegister1];
      rd2 = (bus.ReadRegister2 == ZERO_ADDR) ? '0 : regs_q[bus.ReadRegister2];
`ifdef WB_REGFILE_BYPASS_EN
      // commit already excludes register 0, so the zero register is never bypassed.
      if (commit && (bus.ReadRegister1 == dest_addr)) begin
         rd1 = write_data;
      end
      if (commit && (bus.ReadRegister2 == dest_addr)) begin
         rd2 = write_data;
      end
`endif
   end

   assign bus.ReadData1  = rd1;
   assign bus.ReadData2  = rd2;
   assign bus.WriteData  = write_data;
   assign bus.WriteCount = count_q;

endmodule
